// File: rtl/rmon_pkg.sv
// -----------------------------------------------------------------------------
// rmon_pkg
// Shared definitions for the RMON statistics update engine:
//   - field widths of the MAC stat report and of the counter RAM
//   - packet type encoding (also the type-counter word offset)
//   - word offsets of the byte counter and of the size bins
//   - size-bin length thresholds
//   - FSM state encoding and read-modify-write op indices
// Optional feature macro: RMON_CPU_CLEAR_EN adds the ST_CLR state.
// -----------------------------------------------------------------------------
package rmon_pkg;

    localparam int TYPE_W = 3;
    localparam int LEN_W  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    typedef enum logic [TYPE_W-1:0] {
        PKT_UCAST   = 3'd0,
        PKT_MCAST   = 3'd1,
        PKT_BCAST   = 3'd2,
        PKT_CRC_ERR = 3'd3,
        PKT_RUNT    = 3'd4,
        PKT_JABBER  = 3'd5,
        PKT_PAUSE   = 3'd6,
        PKT_OTHER   = 3'd7
    } pkt_type_e;

    // Word offsets inside one direction block; the type counter sits at
    // offset == type.
    localparam logic [ADDR_W-1:0] BYTE_OFS = 6'd8;
    localparam logic [ADDR_W-1:0] BIN_OFS  = 6'd9;

    // Lower length bounds of the fixed size bins; the upper edge of bin 6
    // is the MAX_LEN parameter.
    localparam logic [LEN_W-1:0] LEN_64   = 16'd64;
    localparam logic [LEN_W-1:0] LEN_128  = 16'd128;
    localparam logic [LEN_W-1:0] LEN_256  = 16'd256;
    localparam logic [LEN_W-1:0] LEN_512  = 16'd512;
    localparam logic [LEN_W-1:0] LEN_1024 = 16'd1024;

    typedef logic [1:0] op_t;
    localparam op_t OP_TYPE  = 2'd0;
    localparam op_t OP_BYTES = 2'd1;
    localparam op_t OP_BIN   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_RD,
        ST_WR,
        ST_DONE
`ifdef RMON_CPU_CLEAR_EN
        , ST_CLR
`endif
    } state_e;

    typedef struct packed {
        pkt_type_e        ptype;
        logic [LEN_W-1:0] len;
    } rmon_event_t;

    // Word offset (within a direction block) touched by a given op.
    function automatic logic [ADDR_W-1:0] op_offset(op_t op, pkt_type_e ptype, logic [2:0] bin);
        case (op)
            OP_TYPE:  return {3'b000, ptype};
            OP_BYTES: return BYTE_OFS;
            default:  return BIN_OFS + {3'b000, bin};
        endcase
    endfunction

endpackage

// File: rtl/rmon_if.sv
// -----------------------------------------------------------------------------
// rmon_if
// Bundles the signals around the RMON update engine:
//   - TX/RX stat reports from the MACs (type, length, apply strobe)
//   - RAM port A (Addra, Dina, Wea out; Douta in, one cycle read latency)
//   - status (Rmon_busy, drop pulses) and CPU clear handshake
// modport master : the rmon_ctrl engine
// modport slave  : its environment (MACs, counter RAM, CPU)
// -----------------------------------------------------------------------------
interface rmon_if;
    import rmon_pkg::*;

    logic [TYPE_W-1:0] Tx_pkt_type_rmon;
    logic [LEN_W-1:0]  Tx_pkt_length_rmon;
    logic              Tx_apply_rmon;
    logic [TYPE_W-1:0] Rx_pkt_type_rmon;
    logic [LEN_W-1:0]  Rx_pkt_length_rmon;
    logic              Rx_apply_rmon;
    logic [ADDR_W-1:0] Addra;
    logic [DATA_W-1:0] Dina;
    logic              Wea;
    logic [DATA_W-1:0] Douta;
    logic              Rmon_busy;
    logic              Rmon_drop_tx;
    logic              Rmon_drop_rx;
    logic              CPU_clr_req;
    logic              CPU_clr_done;

    modport master (
        input  Tx_pkt_type_rmon, Tx_pkt_length_rmon, Tx_apply_rmon,
        input  Rx_pkt_type_rmon, Rx_pkt_length_rmon, Rx_apply_rmon,
        input  Douta, CPU_clr_req,
        output Addra, Dina, Wea, Rmon_busy, Rmon_drop_tx, Rmon_drop_rx, CPU_clr_done
    );

    modport slave (
        output Tx_pkt_type_rmon, Tx_pkt_length_rmon, Tx_apply_rmon,
        output Rx_pkt_type_rmon, Rx_pkt_length_rmon, Rx_apply_rmon,
        output Douta, CPU_clr_req,
        input  Addra, Dina, Wea, Rmon_busy, Rmon_drop_tx, Rmon_drop_rx, CPU_clr_done
    );

endinterface

// File: rtl/rmon_size_bin.sv
// -----------------------------------------------------------------------------
// rmon_size_bin
// Combinational frame-length classifier.
//   i_len     : frame length in bytes
//   i_max_len : upper edge of bin 6 (largest normal frame)
//   o_bin     : 0 (<64), 1 (=64), 2 (65..127), 3 (128..255), 4 (256..511),
//               5 (512..1023), 6 (1024..i_max_len), 7 (>i_max_len)
// -----------------------------------------------------------------------------
module rmon_size_bin
    import rmon_pkg::*;
(
    input  logic [LEN_W-1:0] i_len,
    input  logic [LEN_W-1:0] i_max_len,
    output logic [2:0]       o_bin
);

    always_comb begin
        // NOTE: o_bin gets a default before the priority chain so no path leaves it unassigned (no latch).
        o_bin = 3'd7;
        if (i_len < LEN_64)          o_bin = 3'd0;
        else if (i_len == LEN_64)    o_bin = 3'd1;
        else if (i_len < LEN_128)    o_bin = 3'd2;
        else if (i_len < LEN_256)    o_bin = 3'd3;
        else if (i_len < LEN_512)    o_bin = 3'd4;
        else if (i_len < LEN_1024)   o_bin = 3'd5;
        else if (i_len <= i_max_len) o_bin = 3'd6;
    end

endmodule

// File: rtl/rmon_ctrl.sv
// -----------------------------------------------------------------------------
// rmon_ctrl
// RMON statistics update engine. Captures one TX and one RX packet event,
// arbitrates round-robin, and performs three read-modify-write increments
// per event on counter RAM port A: type counter (+1), byte counter (+len),
// size-bin counter (+1). Counters wrap modulo 2^32.
// Ports:
//   Clk   : single clock shared with the RAM
//   Reset : synchronous, active-high
//   bus   : rmon_if.master (MAC stat inputs, RAM port A, status, CPU clear)
// Optional feature macro: RMON_CPU_CLEAR_EN enables the CPU clear-all
// sequence (64 zero writes); without it CPU_clr_req is ignored and
// CPU_clr_done is tied low.
// -----------------------------------------------------------------------------
module rmon_ctrl
    import rmon_pkg::*;
#(
    parameter int TX_BASE = 0,
    parameter int RX_BASE = 32,
    parameter int MAX_LEN = 1518
) (
    input  logic   Clk,
    input  logic   Reset,
    rmon_if.master bus
);

    localparam logic [ADDR_W-1:0] TX_BASE_A = ADDR_W'(TX_BASE);
    localparam logic [ADDR_W-1:0] RX_BASE_A = ADDR_W'(RX_BASE);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);

    state_e      r_state, w_next;
    rmon_event_t r_tx_ev, r_rx_ev, r_cur_ev;
    logic        r_tx_pend, r_rx_pend;
    logic        r_drop_tx, r_drop_rx;
    logic        r_cur_rx;     // direction of the event being applied
    logic        r_rr_rx;      // 1: RX wins the next tie
    op_t         r_op;
    logic        w_grant_rx, w_take_tx, w_take_rx;
    logic [2:0]  w_bin;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_inc;

    assign w_grant_rx = r_rx_pend && (!r_tx_pend || r_rr_rx);
    assign w_take_tx  = (r_state == ST_SEL) && !w_grant_rx;
    assign w_take_rx  = (r_state == ST_SEL) &&  w_grant_rx;

    // ---------------- event capture ----------------
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_tx_pend <= 1'b0;
            r_rx_pend <= 1'b0;
            r_drop_tx <= 1'b0;
            r_drop_rx <= 1'b0;
        end else begin
            r_drop_tx <= 1'b0;
            r_drop_rx <= 1'b0;
            // The slot frees in the same cycle the FSM takes the held event,
            // so a coinciding strobe reloads it instead of dropping.
            if (bus.Tx_apply_rmon) begin
                if (!r_tx_pend || w_take_tx) r_tx_pend <= 1'b1;
                else                         r_drop_tx <= 1'b1;
            end else if (w_take_tx) begin
                r_tx_pend <= 1'b0;
            end
            if (bus.Rx_apply_rmon) begin
                if (!r_rx_pend || w_take_rx) r_rx_pend <= 1'b1;
                else                         r_drop_rx <= 1'b1;
            end else if (w_take_rx) begin
                r_rx_pend <= 1'b0;
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only read while their pending/state qualifier is set.
    always_ff @(posedge Clk) begin
        if (bus.Tx_apply_rmon && (!r_tx_pend || w_take_tx))
            r_tx_ev <= '{ptype: pkt_type_e'(bus.Tx_pkt_type_rmon), len: bus.Tx_pkt_length_rmon};
        if (bus.Rx_apply_rmon && (!r_rx_pend || w_take_rx))
            r_rx_ev <= '{ptype: pkt_type_e'(bus.Rx_pkt_type_rmon), len: bus.Rx_pkt_length_rmon};
        if (r_state == ST_SEL)
            r_cur_ev <= w_grant_rx ? r_rx_ev : r_tx_ev;
    end

    // ---------------- sequencing registers ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_op     <= OP_TYPE;
            r_cur_rx <= 1'b0;
            r_rr_rx  <= 1'b1;
        end else begin
            case (r_state)
                ST_SEL: begin
                    r_op     <= OP_TYPE;
                    r_cur_rx <= w_grant_rx;
                end
                ST_WR:   if (r_op != OP_BIN) r_op <= r_op + 2'd1;
                ST_DONE: r_rr_rx <= !r_cur_rx;
                default: ;
            endcase
        end
    end

`ifdef RMON_CPU_CLEAR_EN
    logic              r_clr_pend;
    logic              r_clr_done;
    logic [ADDR_W-1:0] r_clr_addr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_clr_pend <= 1'b0;
            r_clr_done <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            r_clr_done <= (r_state == ST_CLR) && (r_clr_addr == '1);
            if (r_state == ST_IDLE && r_clr_pend) begin
                r_clr_pend <= 1'b0;
                r_clr_addr <= '0;
            end else if (bus.CPU_clr_req && r_state != ST_CLR) begin
                r_clr_pend <= 1'b1;
            end
            if (r_state == ST_CLR) r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    assign bus.CPU_clr_done = r_clr_done;
`else
    logic w_unused_clr;
    assign w_unused_clr     = bus.CPU_clr_req;
    assign bus.CPU_clr_done = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef RMON_CPU_CLEAR_EN
                if (r_clr_pend) w_next = ST_CLR;
                else
`endif
                if (r_tx_pend || r_rx_pend) w_next = ST_SEL;
            end
            ST_SEL:  w_next = ST_RD;
            ST_RD:   w_next = ST_WR;
            ST_WR:   w_next = (r_op == OP_BIN) ? ST_DONE : ST_RD;
            ST_DONE: w_next = ST_IDLE;
`ifdef RMON_CPU_CLEAR_EN
            ST_CLR:  if (r_clr_addr == '1) w_next = ST_IDLE;
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    rmon_size_bin u_size_bin (
        .i_len     (r_cur_ev.len),
        .i_max_len (MAX_LEN_L),
        .o_bin     (w_bin)
    );

    assign w_addr = (r_cur_rx ? RX_BASE_A : TX_BASE_A) + op_offset(r_op, r_cur_ev.ptype, w_bin);
    assign w_inc  = (r_op == OP_BYTES) ? {{(DATA_W-LEN_W){1'b0}}, r_cur_ev.len} : 32'd1;

    always_comb begin
        bus.Addra     = '0;
        bus.Dina      = '0;
        bus.Wea       = 1'b0;
        bus.Rmon_busy = (r_state != ST_IDLE);
        case (r_state)
            ST_RD: bus.Addra = w_addr;
            ST_WR: begin
                // Douta holds the word addressed during RD.
                bus.Addra = w_addr;
                bus.Dina  = bus.Douta + w_inc;
                bus.Wea   = 1'b1;
            end
`ifdef RMON_CPU_CLEAR_EN
            ST_CLR: begin
                bus.Addra = r_clr_addr;
                bus.Wea   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.Rmon_drop_tx = r_drop_tx;
    assign bus.Rmon_drop_rx = r_drop_rx;

endmodule

// File: tb/tb_rmon_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rmon_ctrl
// Self-checking bench for rmon_ctrl. Holds a 64x32 counter RAM (port A side)
// and an expected-counter array updated from the packet-level counting rules.
// Optional feature macro: RMON_CPU_CLEAR_EN selects the clear-all scenario.
// -----------------------------------------------------------------------------
module tb_rmon_ctrl;

    localparam int MAX_LEN = 1518;
    localparam int TXB     = 0;
    localparam int RXB     = 32;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk;
    logic reset;
    rmon_if bus_if();

    rmon_ctrl #(.TX_BASE(TXB), .RX_BASE(RXB), .MAX_LEN(MAX_LEN)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- counter RAM ----------------
    logic [31:0] mem [64];
    logic [31:0] exp_mem [64];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)           mem[pre_addr] <= pre_data;
        else if (bus_if.Wea)  mem[bus_if.Addra] <= bus_if.Dina;
        bus_if.Douta <= mem[bus_if.Addra];
    end

    // ---------------- monitor ----------------
    wr_t wr_log[$];
    int  cyc = 0;
    int  n_drop_tx = 0, n_drop_rx = 0, n_done = 0, done_cyc = -1;

    always @(negedge clk) begin
        if (bus_if.Wea) wr_log.push_back('{addr: int'(bus_if.Addra), data: bus_if.Dina, cyc: cyc});
        if (bus_if.Rmon_drop_tx) n_drop_tx++;
        if (bus_if.Rmon_drop_rx) n_drop_rx++;
        if (bus_if.CPU_clr_done) begin
            n_done++;
            done_cyc = cyc;
        end
        cyc++;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int ref_bin(int len);
        if (len < 64)       return 0;
        if (len == 64)      return 1;
        if (len < 128)      return 2;
        if (len < 256)      return 3;
        if (len < 512)      return 4;
        if (len < 1024)     return 5;
        if (len <= MAX_LEN) return 6;
        return 7;
    endfunction

    function automatic void model_event(bit rx, int ptype, int len);
        int b = rx ? RXB : TXB;
        exp_mem[b + ptype]          += 32'd1;
        exp_mem[b + 8]              += 32'(len);
        exp_mem[b + 9 + ref_bin(len)] += 32'd1;
    endfunction

    function automatic int first_diff();
        for (int a = 0; a < 64; a++)
            if (mem[a] !== exp_mem[a]) return a;
        return -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input bit do_tx, input bit do_rx, input bit do_clr,
                         input int tt, input int tl, input int rt, input int rl);
        bus_if.Tx_apply_rmon      = do_tx;
        bus_if.Tx_pkt_type_rmon   = 3'(tt);
        bus_if.Tx_pkt_length_rmon = 16'(tl);
        bus_if.Rx_apply_rmon      = do_rx;
        bus_if.Rx_pkt_type_rmon   = 3'(rt);
        bus_if.Rx_pkt_length_rmon = 16'(rl);
        bus_if.CPU_clr_req        = do_clr;
        @(negedge clk);
        bus_if.Tx_apply_rmon = 1'b0;
        bus_if.Rx_apply_rmon = 1'b0;
        bus_if.CPU_clr_req   = 1'b0;
    endtask

    task automatic ram_word(input int a, input logic [31:0] v);
        pre_we = 1'b1; pre_addr = 6'(a); pre_data = v;
        exp_mem[a] = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic ram_fill(input bit rnd);
        for (int a = 0; a < 64; a++) ram_word(a, rnd ? 32'($urandom) : 32'd0);
    endtask

    task automatic wait_quiet(input int budget);
        int idle = 0;
        int n = 0;
        while (idle < 3 && n < budget) begin
            @(negedge clk);
            n++;
            idle = bus_if.Rmon_busy ? 0 : idle + 1;
        end
        total++;
        if (idle < 3) begin
            $display("FAIL quiet_timeout: busy=%b after %0d cycles, required idle", bus_if.Rmon_busy, n);
            bad++;
        end
    endtask

    task automatic check_ram(input string name);
        int a = first_diff();
        total++;
        if (a != -1) begin
            $display("FAIL %s: ram[%0d]=%h required %h", name, a, mem[a], exp_mem[a]);
            bad++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total += 6;
        if (bus_if.Addra !== 6'd0)      begin $display("FAIL reset_addra: %h required 0", bus_if.Addra); bad++; end
        if (bus_if.Dina !== 32'd0)      begin $display("FAIL reset_dina: %h required 0", bus_if.Dina); bad++; end
        if (bus_if.Wea !== 1'b0)        begin $display("FAIL reset_wea: %b required 0", bus_if.Wea); bad++; end
        if (bus_if.Rmon_busy !== 1'b0)  begin $display("FAIL reset_busy: %b required 0", bus_if.Rmon_busy); bad++; end
        if ({bus_if.Rmon_drop_tx, bus_if.Rmon_drop_rx} !== 2'b00) begin
            $display("FAIL reset_drops: %b required 00", {bus_if.Rmon_drop_tx, bus_if.Rmon_drop_rx}); bad++;
        end
        if (bus_if.CPU_clr_done !== 1'b0) begin $display("FAIL reset_clr_done: %b required 0", bus_if.CPU_clr_done); bad++; end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        int s;
        ram_fill(1'b0);
        s = wr_log.size();
        apply(1, 0, 0, 0, 64, 0, 0);
        model_event(0, 0, 64);
        wait_quiet(40);
        total += 5;
        if (mem[0] !== 32'd1)  begin $display("FAIL basic_type: %0d required 1", mem[0]); bad++; end
        if (mem[8] !== 32'd64) begin $display("FAIL basic_bytes: %0d required 64", mem[8]); bad++; end
        if (mem[10] !== 32'd1) begin $display("FAIL basic_bin: %0d required 1", mem[10]); bad++; end
        if (wr_log.size() - s != 3) begin $display("FAIL basic_wea_cycles: %0d required 3", wr_log.size() - s); bad++; end
        if (bus_if.Rmon_busy !== 1'b0) begin $display("FAIL basic_busy: %b required 0", bus_if.Rmon_busy); bad++; end
        check_ram("basic_ram");
    endtask

    task automatic test_both();
        int s, dtx, drx;
        s = wr_log.size(); dtx = n_drop_tx; drx = n_drop_rx;
        apply(1, 1, 0, 1, 1500, 2, 1519);
        model_event(1, 2, 1519);
        model_event(0, 1, 1500);
        wait_quiet(60);
        total += 4;
        if (wr_log.size() - s != 6) begin
            $display("FAIL both_writes: %0d required 6", wr_log.size() - s); bad++;
        end else begin
            if (wr_log[s].addr != 34 || wr_log[s+1].addr != 40 || wr_log[s+2].addr != 48) begin
                $display("FAIL both_rx_first: addrs %0d,%0d,%0d required 34,40,48",
                         wr_log[s].addr, wr_log[s+1].addr, wr_log[s+2].addr); bad++;
            end
            if (wr_log[s+3].addr != 1 || wr_log[s+4].addr != 8 || wr_log[s+5].addr != 15) begin
                $display("FAIL both_tx_second: addrs %0d,%0d,%0d required 1,8,15",
                         wr_log[s+3].addr, wr_log[s+4].addr, wr_log[s+5].addr); bad++;
            end
        end
        if (n_drop_tx != dtx || n_drop_rx != drx) begin
            $display("FAIL both_drops: tx=%0d rx=%0d required 0", n_drop_tx - dtx, n_drop_rx - drx); bad++;
        end
        check_ram("both_ram");
    endtask

    task automatic test_drop();
        int dtx, drx, la, ta;
        dtx = n_drop_tx; drx = n_drop_rx;
        la = $urandom_range(0, 2000); ta = $urandom_range(0, 7);
        apply(1, 0, 0, 7, 100, 0, 0);                 // TX keeps the FSM busy
        tick(2);
        apply(0, 1, 0, 0, 0, ta, la);                 // held while TX runs
        tick(2);
        apply(0, 1, 0, 0, 0, 5, 1234);                // must be dropped
        model_event(0, 7, 100);
        model_event(1, ta, la);
        wait_quiet(60);
        total += 3;
        if (n_drop_rx - drx != 1) begin $display("FAIL drop_rx_pulses: %0d required 1", n_drop_rx - drx); bad++; end
        if (n_drop_tx != dtx)     begin $display("FAIL drop_tx_pulses: %0d required 0", n_drop_tx - dtx); bad++; end
        if (mem[RXB+8] !== exp_mem[RXB+8]) begin
            $display("FAIL drop_rx_bytes: %h required %h", mem[RXB+8], exp_mem[RXB+8]); bad++;
        end
        check_ram("drop_ram");
    endtask

    task automatic test_take_same_cycle();
        int drx;
        drx = n_drop_rx;
        apply(0, 1, 0, 0, 0, 3, 300);
        tick(1);
        apply(0, 1, 0, 0, 0, 4, 40);                  // lands in the SEL cycle
        model_event(1, 3, 300);
        model_event(1, 4, 40);
        wait_quiet(60);
        total++;
        if (n_drop_rx != drx) begin $display("FAIL take_same_cycle_drop: %0d required 0", n_drop_rx - drx); bad++; end
        check_ram("take_same_cycle_ram");
    endtask

    task automatic test_wrap();
        int t;
        t = $urandom_range(0, 7);
        ram_word(8, 32'hFFFF_FFF0);
        apply(1, 0, 0, t, 32, 0, 0);
        model_event(0, t, 32);
        wait_quiet(40);
        total++;
        if (mem[8] !== 32'h0000_0010) begin $display("FAIL wrap_bytes: %h required 00000010", mem[8]); bad++; end
        check_ram("wrap_ram");
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        apply(1, 0, 0, 3, 300, 0, 0);
        for (int n = 0; n < 20 && !found; n++) begin
            if (bus_if.Wea === 1'b1 && bus_if.Addra === 6'd8) found = 1;
            else @(negedge clk);
        end
        total++;
        if (!found) begin $display("FAIL reset_mid_find_wr: op1 write not seen, required within 20 cycles"); bad++; end
        reset = 1'b1;                                 // sampled at the end of the op1 write cycle
        @(negedge clk);
        total += 2;
        if (bus_if.Wea !== 1'b0)       begin $display("FAIL reset_mid_wea: %b required 0", bus_if.Wea); bad++; end
        if (bus_if.Rmon_busy !== 1'b0) begin $display("FAIL reset_mid_busy: %b required 0", bus_if.Rmon_busy); bad++; end
        reset = 1'b0;
        exp_mem[TXB+3] += 32'd1;                      // ops 0 and 1 completed, bin lost
        exp_mem[TXB+8] += 32'd300;
        tick(2);
        apply(1, 0, 0, 5, 2000, 0, 0);
        model_event(0, 5, 2000);
        wait_quiet(40);
        total++;
        if (mem[TXB+13] !== exp_mem[TXB+13]) begin
            $display("FAIL reset_mid_bin: %h required %h", mem[TXB+13], exp_mem[TXB+13]); bad++;
        end
        check_ram("reset_mid_ram");
    endtask

`ifdef RMON_CPU_CLEAR_EN
    task automatic test_clear();
        int s, d, last_cyc;
        bit seq_ok = 1;
        ram_fill(1'b1);
        s = wr_log.size(); d = n_done;
        apply(0, 1, 0, 0, 0, 6, 77);
        model_event(1, 6, 77);
        tick(2);
        apply(1, 0, 1, 2, 900, 0, 0);                 // TX held, clear requested
        for (int a = 0; a < 64; a++) exp_mem[a] = 32'd0;
        model_event(0, 2, 900);
        tick(20);
        apply(0, 0, 1, 0, 0, 0, 0);                   // during CLR: ignored
        wait_quiet(200);
        total += 3;
        if (wr_log.size() - s != 70) begin
            $display("FAIL clear_writes: %0d required 70", wr_log.size() - s); bad++;
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (wr_log[s+3+i].addr != i || wr_log[s+3+i].data !== 32'd0 ||
                    wr_log[s+3+i].cyc != wr_log[s+3].cyc + i) seq_ok = 0;
            end
            last_cyc = wr_log[s+66].cyc;
            if (!seq_ok) begin $display("FAIL clear_sequence: zero writes not 0..63 consecutive"); bad++; end
            if (done_cyc != last_cyc + 1) begin
                $display("FAIL clear_done_timing: cycle %0d required %0d", done_cyc, last_cyc + 1); bad++;
            end
        end
        if (n_done - d != 1) begin $display("FAIL clear_done_pulses: %0d required 1", n_done - d); bad++; end
        check_ram("clear_ram");
    endtask
`else
    task automatic test_clear_ignored();
        int s, d;
        s = wr_log.size(); d = n_done;
        apply(0, 0, 1, 0, 0, 0, 0);
        tick(80);
        total += 2;
        if (wr_log.size() != s) begin $display("FAIL clear_ignored_writes: %0d required 0", wr_log.size() - s); bad++; end
        if (n_done != d)        begin $display("FAIL clear_ignored_done: %0d required 0", n_done - d); bad++; end
        check_ram("clear_ignored_ram");
    endtask
`endif

    task automatic test_random();
        int lens[16] = '{0, 1, 63, 64, 65, 127, 128, 255, 256, 511, 512, 1023, 1024, 1518, 1519, 65535};
        int dtx, drx;
        ram_fill(1'b1);
        dtx = n_drop_tx; drx = n_drop_rx;
        for (int i = 0; i < 30; i++) begin
            int mode = $urandom_range(0, 2);
            int tt = $urandom_range(0, 7);
            int rt = $urandom_range(0, 7);
            int tl = $urandom_range(0, 1) ? lens[$urandom_range(0, 15)] : $urandom_range(0, 65535);
            int rl = $urandom_range(0, 1) ? lens[$urandom_range(0, 15)] : $urandom_range(0, 65535);
            bit dt = (mode != 1);
            bit dr = (mode != 0);
            apply(dt, dr, 0, tt, tl, rt, rl);
            if (dt) model_event(0, tt, tl);
            if (dr) model_event(1, rt, rl);
            wait_quiet(60);
            check_ram("random_ram");
        end
        total++;
        if (n_drop_tx != dtx || n_drop_rx != drx) begin
            $display("FAIL random_drops: tx=%0d rx=%0d required 0", n_drop_tx - dtx, n_drop_rx - drx); bad++;
        end
    endtask

    initial begin
        reset = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        bus_if.Tx_apply_rmon = 1'b0; bus_if.Tx_pkt_type_rmon = '0; bus_if.Tx_pkt_length_rmon = '0;
        bus_if.Rx_apply_rmon = 1'b0; bus_if.Rx_pkt_type_rmon = '0; bus_if.Rx_pkt_length_rmon = '0;
        bus_if.CPU_clr_req = 1'b0;
        for (int a = 0; a < 64; a++) exp_mem[a] = 32'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_both();
        test_drop();
        test_take_same_cycle();
        test_wrap();
        test_reset_mid();
`ifdef RMON_CPU_CLEAR_EN
        test_clear();
`else
        test_clear_ignored();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
